vis_unpacker: RTL and testbench

VIS_UNPACKER -- requirements
Module: vis_unpacker

---
 rtl/vis_unpacker_pkg.sv | 10 +
 rtl/vis_unpacker_if.sv | 27 ++
 rtl/vis_unpacker.sv | 143 ++++++++++++++
 tb/tb_vis_unpacker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vis_unpacker_pkg.sv
// vis_pkg: shared state encoding and default sizing for the visibility unpacker.
package vis_pkg;

  localparam int ACCUM_DEF = 32;
  localparam int NVIS_DEF  = 8;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

endpackage

// File: rtl/vis_unpacker_if.sv
// vis_unpacker_if: byte-in / complex-word-out stream bundle for vis_unpacker.
interface vis_unpacker_if
  import vis_pkg::*;
#(
  parameter int ACCUM = ACCUM_DEF
);
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tkeep;
  logic             s_tlast;
  logic [7:0]       s_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [ACCUM-1:0] m_revis;
  logic [ACCUM-1:0] m_imvis;

  modport slave (
    input  s_tvalid, s_tkeep, s_tlast, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tlast, m_revis, m_imvis
  );

  modport master (
    output s_tvalid, s_tkeep, s_tlast, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tlast, m_revis, m_imvis
  );
endinterface

// File: rtl/vis_unpacker.sv
// vis_unpacker: assembles little-endian bytes into {revis, imvis} words and counts frames.
// Framing checks (short word, frame length) are compiled in with VIS_UNPACK_CHECK_EN.
module vis_unpacker
  import vis_pkg::*;
#(
  parameter int ACCUM = ACCUM_DEF,
  parameter int NVIS  = NVIS_DEF,
  parameter int FBITS = 16
) (
  input  logic             clock,
  input  logic             reset,
  vis_unpacker_if.slave    bus,
  output logic [FBITS-1:0] frame_cnt_o,
  output logic             err_short_o,
  output logic             err_len_o
);
  localparam int WBITS = 2 * ACCUM;
  localparam int NB    = WBITS / 8;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

  if (ACCUM < 8 || (ACCUM % 4) != 0 || NVIS < 1) begin : g_bad_cfg
    $error("vis_unpacker: unsupported ACCUM/NVIS");
  end

  logic [0:0]       state_q, state_d;
  logic [BW-1:0]    idx_q, idx_d;
  logic [WBITS-1:0] asm_q, asm_d;
  logic [WBITS-1:0] word_q, word_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [FBITS-1:0] fc_q, fc_d;
  logic [WBITS-1:0] shifted;
  logic             s_fire, m_fire;

`ifdef VIS_UNPACK_CHECK_EN
  localparam int WIW = (NVIS > 1) ? $clog2(NVIS) : 1;
  logic [WIW-1:0] wi_q, wi_d;
  logic           es_q, es_d;
  logic           el_q, el_d;
`endif

  assign bus.s_tready = !m_valid_q || bus.m_tready;
  assign s_fire       = bus.s_tvalid && bus.s_tready;
  assign m_fire       = m_valid_q && bus.m_tready;
  // Bytes enter at the top; after NB shifts byte 0 sits in the low lane.
  assign shifted      = {bus.s_tdata, asm_q[WBITS-1:8]};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    word_d    = word_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    fc_d      = fc_q;
`ifdef VIS_UNPACK_CHECK_EN
    wi_d      = wi_q;
    es_d      = es_q;
    el_d      = el_q;
`endif
    if (m_fire) begin
      m_valid_d = 1'b0;
      if (m_last_q) fc_d = fc_q + FBITS'(1);
    end
    if (s_fire) begin
      if (state_q == ST_DROP) begin
        if (bus.s_tlast) state_d = ST_FILL;
      end else if (bus.s_tkeep && idx_q == BW'(NB - 1)) begin
        word_d    = shifted;
        m_valid_d = 1'b1;
        m_last_d  = bus.s_tlast;
        idx_d     = '0;
`ifdef VIS_UNPACK_CHECK_EN
        if (bus.s_tlast) begin
          el_d = el_q | (wi_q != WIW'(NVIS - 1));
          wi_d = '0;
        end else if (wi_q == WIW'(NVIS - 1)) begin
          el_d    = 1'b1;
          state_d = ST_DROP;
          wi_d    = '0;
        end else begin
          wi_d = wi_q + WIW'(1);
        end
`endif
      end else if (bus.s_tlast) begin
        // A frame ending mid-word abandons the partial word.
        idx_d = '0;
`ifdef VIS_UNPACK_CHECK_EN
        es_d = es_q | bus.s_tkeep;
        wi_d = '0;
`endif
      end else if (bus.s_tkeep) begin
        asm_d = shifted;
        idx_d = idx_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FILL;
      idx_q     <= '0;
      asm_q     <= '0;
      word_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      fc_q      <= '0;
`ifdef VIS_UNPACK_CHECK_EN
      wi_q      <= '0;
      es_q      <= 1'b0;
      el_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      word_q    <= word_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      fc_q      <= fc_d;
`ifdef VIS_UNPACK_CHECK_EN
      wi_q      <= wi_d;
      es_q      <= es_d;
      el_q      <= el_d;
`endif
    end
  end

  assign bus.m_tvalid = m_valid_q;
  assign bus.m_tlast  = m_last_q;
  assign bus.m_revis  = word_q[WBITS-1:ACCUM];
  assign bus.m_imvis  = word_q[ACCUM-1:0];
  assign frame_cnt_o  = fc_q;

`ifdef VIS_UNPACK_CHECK_EN
  assign err_short_o = es_q;
  assign err_len_o   = el_q;
`else
  assign err_short_o = 1'b0;
  assign err_len_o   = 1'b0;
`endif

endmodule

// File: tb/tb_vis_unpacker.sv
// tb_vis_unpacker: directed and randomized byte streams checked every cycle against a
// queue-based frame model; framing-check expectations follow VIS_UNPACK_CHECK_EN.
module tb_vis_unpacker;
  import vis_pkg::*;

  localparam int ACCUM = 32;
  localparam int NVIS  = 4;
  localparam int FBITS = 4;
  localparam int NB    = 2 * ACCUM / 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [FBITS-1:0] frame_cnt_o;
  logic             err_short_o;
  logic             err_len_o;

  vis_unpacker_if #(.ACCUM(ACCUM)) bus ();

  vis_unpacker #(.ACCUM(ACCUM), .NVIS(NVIS), .FBITS(FBITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .frame_cnt_o (frame_cnt_o),
    .err_short_o (err_short_o),
    .err_len_o   (err_len_o)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes in, whole words out, in frame order.
  typedef struct packed {
    logic             last;
    logic [2*ACCUM-1:0] word;
  } wexp_t;

  wexp_t        exp_q[$];
  logic [7:0]   part_q[$];
  bit           drop_m = 0;
  int           wi_m = 0;
  bit           es_m = 0;
  bit           el_m = 0;
  int           fc_m = 0;
  bit           chk_on = 0;
  int           n_words = 0;
  logic [ACCUM-1:0] seen_re, seen_im;
  logic         seen_last;
  int           rdy_mode = 0;

  task automatic model_byte(input logic [7:0] d, input logic k, input logic l);
    logic [2*ACCUM-1:0] w;
    wexp_t e;
    if (drop_m) begin
      if (l) drop_m = 0;
      return;
    end
    if (k) part_q.push_back(d);
    if (part_q.size() == NB) begin
      w = '0;
      for (int i = 0; i < NB; i++) w[8*i +: 8] = part_q[i];
      e.last = l;
      e.word = w;
      exp_q.push_back(e);
      part_q.delete();
`ifdef VIS_UNPACK_CHECK_EN
      if (l) begin
        if (wi_m != NVIS - 1) el_m = 1;
        wi_m = 0;
      end else if (wi_m == NVIS - 1) begin
        el_m   = 1;
        drop_m = 1;
        wi_m   = 0;
      end else begin
        wi_m++;
      end
`endif
    end else if (l) begin
`ifdef VIS_UNPACK_CHECK_EN
      if (k) es_m = 1;
      wi_m = 0;
`endif
      part_q.delete();
    end
  endtask

  always @(negedge clock) begin
    case (rdy_mode)
      0:       bus.m_tready = 1'b1;
      1:       bus.m_tready = ($urandom_range(0, 3) != 0);
      default: bus.m_tready = 1'b0;
    endcase
  end

  // Compare process: outputs vs model each cycle, then advance the model by this cycle's handshakes.
  always @(negedge clock) begin
    bit    mv;
    wexp_t h;
    #2;
    mv = (exp_q.size() != 0);
    if (chk_on) begin
      chk("m_tvalid", bus.m_tvalid, mv);
      chk("s_tready", bus.s_tready, !mv || bus.m_tready);
      if (mv) begin
        h = exp_q[0];
        chk("m_revis", bus.m_revis, h.word[2*ACCUM-1:ACCUM]);
        chk("m_imvis", bus.m_imvis, h.word[ACCUM-1:0]);
        chk("m_tlast", bus.m_tlast, h.last);
      end
      chk("frame_cnt", frame_cnt_o, fc_m);
      chk("err_short", err_short_o, es_m);
      chk("err_len", err_len_o, el_m);
    end
    if (reset) begin
      exp_q.delete();
      part_q.delete();
      drop_m = 0;
      wi_m   = 0;
      es_m   = 0;
      el_m   = 0;
      fc_m   = 0;
    end else begin
      if (mv && bus.m_tready) begin
        h = exp_q.pop_front();
        seen_re   = bus.m_revis;
        seen_im   = bus.m_imvis;
        seen_last = bus.m_tlast;
        n_words++;
        if (h.last) fc_m = (fc_m + 1) % (1 << FBITS);
      end
      if (bus.s_tvalid && bus.s_tready) model_byte(bus.s_tdata, bus.s_tkeep, bus.s_tlast);
    end
  end

  task automatic send(input logic [7:0] d, input logic k, input logic l);
    int budget;
    budget = 200;
    bus.s_tdata  = d;
    bus.s_tkeep  = k;
    bus.s_tlast  = l;
    bus.s_tvalid = 1'b1;
    #1;
    while (!bus.s_tready && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", d);
    end
    @(negedge clock);
    bus.s_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] base, input logic l);
    for (int i = 0; i < NB; i++) send(base + 8'(i), 1'b1, l && (i == NB - 1));
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    do begin
      @(negedge clock);
      #3;
      b++;
    end while (exp_q.size() != 0 && b < 200);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input bit with_byte);
    reset = 1'b1;
    if (with_byte) begin
      bus.s_tdata  = 8'hEE;
      bus.s_tkeep  = 1'b1;
      bus.s_tlast  = 1'b0;
      bus.s_tvalid = 1'b1;
    end
    @(negedge clock);
    reset        = 1'b0;
    bus.s_tvalid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " m_tvalid"}, bus.m_tvalid, 0);
    chk({tag, " m_tlast"}, bus.m_tlast, 0);
    chk({tag, " m_revis"}, bus.m_revis, 0);
    chk({tag, " m_imvis"}, bus.m_imvis, 0);
    chk({tag, " frame_cnt"}, frame_cnt_o, 0);
    chk({tag, " err_short"}, err_short_o, 0);
    chk({tag, " err_len"}, err_len_o, 0);
    chk({tag, " s_tready"}, bus.s_tready, 1);
  endtask

  int n0;
  int sb;

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tkeep  = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = 8'h00;
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    chk_on = 1;
    chk_zero("reset");

    // Basic word: bytes 01..08
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b1, i == 8);
    wait_idle();
    chk("basic imvis", seen_im, 32'h04030201);
    chk("basic revis", seen_re, 32'h08070605);
    chk("basic tlast", seen_last, 1);
    chk("basic frame_cnt", frame_cnt_o, 1);

    // Two-word frame with a 10-cycle output stall after the first word
    do_reset(0);
    n0 = n_words;
    rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 16; i++) send(8'h11 + 8'(i), 1'b1, i == 15);
      end
      begin
        sb = 0;
        while (!bus.m_tvalid && sb < 200) begin
          @(negedge clock);
          sb++;
        end
        chk("stall first word seen", bus.m_tvalid, 1);
        repeat (10) begin
          @(negedge clock);
          #1;
          chk("stall s_tready", bus.s_tready, 0);
          chk("stall imvis", bus.m_imvis, 32'h14131211);
          chk("stall revis", bus.m_revis, 32'h18171615);
          chk("stall tlast", bus.m_tlast, 0);
        end
        rdy_mode = 0;
      end
    join
    wait_idle();
    chk("stall words", n_words - n0, 2);
    chk("stall 2nd imvis", seen_im, 32'h1c1b1a19);
    chk("stall 2nd revis", seen_re, 32'h201f1e1d);
    chk("stall frame_cnt", frame_cnt_o, 1);

    // Reset mid-word, with a byte presented during reset
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b1, 1'b0);
    do_reset(1);
    chk_zero("midreset");
    send_word(8'h31, 1'b1);
    wait_idle();
    chk("post-reset imvis", seen_im, 32'h34333231);
    chk("post-reset revis", seen_re, 32'h38373635);
    chk("post-reset frame_cnt", frame_cnt_o, 1);

    // Short tlast on byte 5
    do_reset(0);
    n0 = n_words;
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 1'b1, i == 4);
    repeat (2) @(negedge clock);
    chk("short words", n_words - n0, 0);
    chk("short m_tvalid", bus.m_tvalid, 0);
`ifdef VIS_UNPACK_CHECK_EN
    chk("short err_short", err_short_o, 1);
`else
    chk("short err_short", err_short_o, 0);
`endif
    send_word(8'h51, 1'b1);
    wait_idle();
    chk("after short imvis", seen_im, 32'h54535251);
    chk("after short revis", seen_re, 32'h58575655);

    // Three-word frame (NVIS=4)
    do_reset(0);
    n0 = n_words;
    for (int w = 0; w < 3; w++) send_word(8'h61 + 8'(8 * w), w == 2);
    wait_idle();
    chk("len words", n_words - n0, 3);
    chk("len frame_cnt", frame_cnt_o, 1);
`ifdef VIS_UNPACK_CHECK_EN
    chk("len err_len", err_len_o, 1);
`else
    chk("len err_len", err_len_o, 0);
`endif

    // NVIS words without tlast, then trailing bytes ending in tlast, then a clean word
    do_reset(0);
    n0 = n_words;
    for (int w = 0; w < NVIS; w++) send_word(8'h80 + 8'(8 * w), 1'b0);
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 1'b1, i == 4);
    send_word(8'hD1, 1'b1);
    wait_idle();
    chk("overrun words", n_words - n0, NVIS + 1);
    chk("overrun imvis", seen_im, 32'hd4d3d2d1);
    chk("overrun err_short", err_short_o, 0);

    // Frame counter wrap at 2^FBITS
    do_reset(0);
    for (int f = 0; f < 15; f++) send_word(8'(f), 1'b1);
    wait_idle();
    chk("fc 15", frame_cnt_o, 15);
    send_word(8'hF0, 1'b1);
    wait_idle();
    chk("fc wrap", frame_cnt_o, 0);

    // Randomized traffic with backpressure, gaps, dropped bytes and one mid-stream reset
    do_reset(0);
    rdy_mode = 1;
    for (int i = 0; i < 900; i++) begin
      logic k, l;
      k = ($urandom_range(0, 7) != 0);
      l = k && ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0) @(negedge clock);
      if (i == 450) do_reset($urandom_range(0, 1) == 1);
      send(8'($urandom), k, l);
    end
    rdy_mode = 0;
    wait_idle();
    chk("random drained", bus.m_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
